ama_riscv_mmio: RTL and testbench
=================================

# ama_riscv_mmio

Parametrised MMIO controller between the core's memory-mapped I/O port and the UART and performance-counter logic. It holds the cycle and instruction counters internally, with configurable width. UART traffic is buffered in TX and RX FIFOs of configurable depth, using valid/ready handshakes on the UART side. Reads have one-cycle registered latency, matching DMEM, so the core's load path treats MMIO and DMEM identically.

## Interface
- `TX_DEPTH`, 4: TX FIFO entries; power of two, ≥2.
- `RX_DEPTH`, 4: RX FIFO entries; power of two, ≥2.
- `CNT_W`, 64: counter width; 32..64.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mmio_en` in 1: core access strobe, one cycle per access.
- `mmio_we` in 4: byte write enables; all zero means read.
- `mmio_addr` in 3: word offset within the MMIO region.
- `mmio_wdata` in 32: write data.
- `mmio_rdata` out 32: registered read data.
- `inst_retired` in 1: one pulse per retired instruction.
- `uart_tx_data` out 8: byte to UART transmitter.
- `uart_tx_valid` out 1: TX FIFO non-empty.
- `uart_tx_ready` in 1: transmitter accepts the byte.
- `uart_rx_data` in 8: received byte.
- `uart_rx_valid` in 1: received byte present.
- `uart_rx_ready` out 1: RX FIFO not full.

## Operation
Register map, by word offset:
- 0 CTRL (write-only):
  - bit0 = 1 zeroes both counters.
  - bit1 = 1 clears `tx_ovf`.
  - Write takes effect only when `mmio_we[0]` = 1.
- 1 STATUS (read-only):
  - [0] `rx_nonempty`
  - [1] `tx_full`
  - [2] `tx_ovf` (sticky)
  - [15:8] RX count
  - [23:16] TX count
- 2 TX_DATA (write):
  - `mmio_wdata[7:0]` is pushed when `mmio_we[0]` = 1.
- 3 RX_DATA (read):
  - Returns the head byte, zero-extended, and pops it.
  - When RX is empty: returns 0, no pop.
- 4 CYCLE_LO / 5 INSTR_LO (read):
  - Return counter bits [31:0].
  - The same read latches counter bits [CNT_W-1:32] into that counter's shadow register.
- 6 CYCLE_HI / 7 INSTR_HI (read):
  - Return that counter's shadow register, zero-extended.
  - Return 0 when `CNT_W` = 32.
- Writes to read-only offsets and reads of CTRL/TX_DATA are ignored and return 0, with no side effects.

Counters:
- Cycle counter: +1 every cycle.
- Instruction counter: +1 on each `inst_retired`.
- Both wrap modulo 2^CNT_W.
- A CTRL reset write wins over a same-cycle increment; the counter reads 0 the next cycle.
- Read values are the counter state before that cycle's update.

FIFOs (two independent circular buffers):
- Read/write pointers carry one extra wrap bit for full/empty detection.
- TX push: core write to offset 2. TX pop: `uart_tx_valid && uart_tx_ready`.
- RX push: `uart_rx_valid && uart_rx_ready`. RX pop: core read of offset 3 while non-empty.
- TX write while full:
  - If a TX pop occurs the same cycle, the write is accepted and the count is unchanged.
  - Otherwise the write is dropped and `tx_ovf` is set.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both operations complete.
- RX cannot overflow, because `uart_rx_ready` = !rx_full.

## Timing
- Read latency is 1 cycle: `mmio_rdata` is valid the cycle after `mmio_en` with `mmio_we` = 0.
- `mmio_rdata` holds its value until the next read.
- Pop, shadow latch, and counter/flag updates all occur at the edge ending the access cycle.
- A status read sees state from before the same-cycle access.
- `uart_tx_data`/`uart_tx_valid` come from FIFO state registers; no combinational path from `uart_tx_ready`.
- `uart_rx_ready` comes from registered count only.
- Reset values:
  - `mmio_rdata` = 0, `uart_tx_valid` = 0, `uart_tx_data` = 0, `uart_rx_ready` = 1.
  - Counters, shadows, pointers and `tx_ovf` = 0.
- Reset asserted mid-operation: FIFO contents are discarded immediately (asynchronous); in-flight read data is lost. Operation resumes on the first edge after release.

## Test plan
- Reset release, then read offset 4 at cycle 10 → returns 10 ±0 relative to the release edge. Reading offset 6 afterwards → 0.
- Pulse `inst_retired` 5 times, write CTRL = 1 in the same cycle as the 5th pulse → the next read of offset 5 returns 0.
- Preload the cycle counter to 0xFFFF_FFFF_FFFF_FFFE via force, then read 4 then 6 across the wrap → the pair is coherent (0xFFFFFFFF/0xFFFFFFFF or later wrap 0/0), never mixed.
- Hold `uart_tx_ready` = 0 and write 5 bytes with `TX_DEPTH` = 4 → STATUS = tx_full, tx_ovf, TX count 4. Then release ready → bytes 1-4 drain in order and byte 5 is absent.
- Push 4 RX bytes 0xA1..0xA4 → `uart_rx_ready` = 0. Read offset 3 ×5 → returns 0xA1..0xA4, then 0. `uart_rx_ready` returns to 1 the cycle after the first pop.
- Assert `rst` low with 2 bytes in TX → `uart_tx_valid` drops without waiting for a clock edge, and STATUS reads 0 after release.

Source files
------------

// File: rtl/ama_riscv_mmio.sv
// MMIO controller: cycle/instruction counters with hi-word shadows, plus UART TX/RX FIFOs.
// Reads are registered (one-cycle latency) so the core load path matches DMEM.
module ama_riscv_mmio #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int CNT_W    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_en,
    input  logic [3:0]  mmio_we,
    input  logic [2:0]  mmio_addr,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    input  logic        inst_retired,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    localparam logic [2:0] OFS_CTRL   = 3'd0;
    localparam logic [2:0] OFS_STATUS = 3'd1;
    localparam logic [2:0] OFS_TX     = 3'd2;
    localparam logic [2:0] OFS_RX     = 3'd3;
    localparam logic [2:0] OFS_CYC_LO = 3'd4;
    localparam logic [2:0] OFS_INS_LO = 3'd5;
    localparam logic [2:0] OFS_CYC_HI = 3'd6;
    localparam logic [2:0] OFS_INS_HI = 3'd7;

    localparam logic [TX_AW:0]   TX_ONE  = (TX_AW+1)'(1);
    localparam logic [RX_AW:0]   RX_ONE  = (RX_AW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Bits above 31 of a counter; zero when the counter is only 32 bits wide.
    function automatic logic [31:0] hi_word(input logic [CNT_W-1:0] c);
        return 32'(64'(c) >> 32);
    endfunction

    logic rd_p0;
    logic wr0_p0;
    logic ctrl_wr_p0;
    logic clr_cnt_p0;
    logic clr_ovf_p0;

    assign rd_p0      = mmio_en && (mmio_we == 4'b0000);
    assign wr0_p0     = mmio_en && mmio_we[0];
    assign ctrl_wr_p0 = wr0_p0 && (mmio_addr == OFS_CTRL);
    assign clr_cnt_p0 = ctrl_wr_p0 && mmio_wdata[0];
    assign clr_ovf_p0 = ctrl_wr_p0 && mmio_wdata[1];

    logic unused_wdata;
    assign unused_wdata = ^mmio_wdata[31:8];

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW:0] tx_wptr;
    logic [TX_AW:0] tx_rptr;
    logic [TX_AW:0] tx_cnt;
    logic           tx_full;
    logic           tx_empty;
    logic           tx_push_req;
    logic           tx_push;
    logic           tx_pop;
    logic           tx_ovf;

    assign tx_cnt      = tx_wptr - tx_rptr;
    assign tx_full     = (tx_cnt == (TX_AW+1)'(TX_DEPTH));
    assign tx_empty    = (tx_cnt == '0);
    assign tx_push_req = wr0_p0 && (mmio_addr == OFS_TX);
    assign tx_pop      = !tx_empty && uart_tx_ready;
    // A full FIFO still takes the write when the head leaves in the same cycle.
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);

    assign uart_tx_valid = !tx_empty;
    assign uart_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr[TX_AW-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[TX_AW-1:0]] <= mmio_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_ovf  <= 1'b0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + TX_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + TX_ONE;
            if (clr_ovf_p0)                 tx_ovf <= 1'b0;
            else if (tx_push_req && !tx_push) tx_ovf <= 1'b1;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW:0] rx_wptr;
    logic [RX_AW:0] rx_rptr;
    logic [RX_AW:0] rx_cnt;
    logic           rx_full;
    logic           rx_empty;
    logic           rx_push;
    logic           rx_pop;

    assign rx_cnt        = rx_wptr - rx_rptr;
    assign rx_full       = (rx_cnt == (RX_AW+1)'(RX_DEPTH));
    assign rx_empty      = (rx_cnt == '0);
    assign uart_rx_ready = !rx_full;
    assign rx_push       = uart_rx_valid && !rx_full;
    assign rx_pop        = rd_p0 && (mmio_addr == OFS_RX) && !rx_empty;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[RX_AW-1:0]] <= uart_rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + RX_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + RX_ONE;
        end
    end

    // ---------------- counters and hi-word shadows ----------------
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ins_cnt;
    logic [31:0]      cyc_shadow;
    logic [31:0]      ins_shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt    <= '0;
            ins_cnt    <= '0;
            cyc_shadow <= '0;
            ins_shadow <= '0;
        end else begin
            if (clr_cnt_p0)        cyc_cnt <= '0;
            else                   cyc_cnt <= cyc_cnt + CNT_ONE;
            if (clr_cnt_p0)        ins_cnt <= '0;
            else if (inst_retired) ins_cnt <= ins_cnt + CNT_ONE;
            // The lo read freezes the matching hi half so a later hi read is coherent.
            if (rd_p0 && (mmio_addr == OFS_CYC_LO)) cyc_shadow <= hi_word(cyc_cnt);
            if (rd_p0 && (mmio_addr == OFS_INS_LO)) ins_shadow <= hi_word(ins_cnt);
        end
    end

    // ---------------- read mux / p0 -> p1 boundary ----------------
    logic [31:0] rdata_p0;

    always_comb begin
        rdata_p0 = '0;
        case (mmio_addr)
            OFS_STATUS: rdata_p0 = {8'h00, 8'(tx_cnt), 8'(rx_cnt), 5'h00, tx_ovf, tx_full, !rx_empty};
            OFS_RX:     rdata_p0 = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rptr[RX_AW-1:0]]};
            OFS_CYC_LO: rdata_p0 = cyc_cnt[31:0];
            OFS_INS_LO: rdata_p0 = ins_cnt[31:0];
            OFS_CYC_HI: rdata_p0 = cyc_shadow;
            OFS_INS_HI: rdata_p0 = ins_shadow;
            default:    rdata_p0 = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       mmio_rdata <= '0;
        else if (rd_p0) mmio_rdata <= rdata_p0;
    end

endmodule

// File: tb/tb_ama_riscv_mmio.sv
// Directed bench for ama_riscv_mmio: counters, shadow coherence, TX/RX FIFOs and async reset.
module tb_ama_riscv_mmio;

    logic        clk;
    logic        rst;
    logic        mmio_en;
    logic [3:0]  mmio_we;
    logic [2:0]  mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        inst_retired;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    ama_riscv_mmio #(.TX_DEPTH(4), .RX_DEPTH(4), .CNT_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .mmio_en      (mmio_en),
        .mmio_we      (mmio_we),
        .mmio_addr    (mmio_addr),
        .mmio_wdata   (mmio_wdata),
        .mmio_rdata   (mmio_rdata),
        .inst_retired (inst_retired),
        .uart_tx_data (uart_tx_data),
        .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_ready(uart_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One core access per call; on return mmio_rdata holds the result of a read.
    task automatic acc(input logic [2:0] a, input logic [3:0] w, input logic [31:0] d);
        mmio_en    = 1'b1;
        mmio_we    = w;
        mmio_addr  = a;
        mmio_wdata = d;
        @(negedge clk);
        mmio_en    = 1'b0;
        mmio_we    = 4'h0;
        mmio_wdata = 32'h0;
    endtask

    initial begin
        rst = 1'b0;
        mmio_en = 1'b0; mmio_we = 4'h0; mmio_addr = 3'h0; mmio_wdata = 32'h0;
        inst_retired = 1'b0; uart_tx_ready = 1'b0;
        uart_rx_data = 8'h00; uart_rx_valid = 1'b0;

        vecs[0]  = '{3'd2, 4'b0001, 32'h11, 1'b0, 32'h0};
        vecs[1]  = '{3'd2, 4'b0001, 32'h12, 1'b0, 32'h0};
        vecs[2]  = '{3'd2, 4'b0001, 32'h13, 1'b0, 32'h0};
        vecs[3]  = '{3'd2, 4'b0001, 32'h14, 1'b0, 32'h0};
        vecs[4]  = '{3'd2, 4'b0001, 32'h15, 1'b0, 32'h0};
        vecs[5]  = '{3'd1, 4'b0000, 32'h0,  1'b1, 32'h0004_0006};
        vecs[6]  = '{3'd0, 4'b0000, 32'h0,  1'b1, 32'h0};
        vecs[7]  = '{3'd2, 4'b0000, 32'h0,  1'b1, 32'h0};
        vecs[8]  = '{3'd1, 4'b1111, 32'h0,  1'b0, 32'h0};
        vecs[9]  = '{3'd0, 4'b0010, 32'h3,  1'b0, 32'h0};
        vecs[10] = '{3'd1, 4'b0000, 32'h0,  1'b1, 32'h0004_0006};

        // Reset state
        #12;
        check("rst_rdata",    mmio_rdata, 32'h0);
        check("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
        check("rst_tx_data",  32'(uart_tx_data), 32'h0);
        check("rst_rx_ready", 32'(uart_rx_ready), 32'h1);

        // Cycle counter relative to release edge
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        acc(3'd4, 4'h0, 32'h0);
        check("cyc_lo_at_10", mmio_rdata, 32'd10);
        acc(3'd6, 4'h0, 32'h0);
        check("cyc_hi_small", mmio_rdata, 32'h0);

        // Instruction counter and clear-wins-over-increment
        for (int i = 0; i < 3; i++) begin
            inst_retired = 1'b1;
            @(negedge clk);
        end
        inst_retired = 1'b0;
        acc(3'd5, 4'h0, 32'h0);
        check("ins_lo_3", mmio_rdata, 32'd3);
        inst_retired = 1'b1;
        @(negedge clk);
        acc(3'd0, 4'b0001, 32'h1);
        inst_retired = 1'b0;
        acc(3'd4, 4'h0, 32'h0);
        check("cyc_after_clr", mmio_rdata, 32'h0);
        acc(3'd5, 4'h0, 32'h0);
        check("ins_after_clr", mmio_rdata, 32'h0);

        // Coherent lo/hi pair across the 64-bit wrap
        force dut.cyc_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.cyc_cnt;
        @(negedge clk);
        acc(3'd4, 4'h0, 32'h0);
        check("wrap_lo", mmio_rdata, 32'hFFFF_FFFF);
        acc(3'd6, 4'h0, 32'h0);
        check("wrap_hi", mmio_rdata, 32'hFFFF_FFFF);
        acc(3'd4, 4'h0, 32'h0);
        check("post_wrap_lo", mmio_rdata, 32'h1);
        acc(3'd6, 4'h0, 32'h0);
        check("post_wrap_hi", mmio_rdata, 32'h0);

        // TX overflow and ignored accesses, table-driven
        for (int i = 0; i < 11; i++) begin
            acc(vecs[i].addr, vecs[i].we, vecs[i].wdata);
            if (vecs[i].chk) check($sformatf("vec%0d", i), mmio_rdata, vecs[i].exp);
        end
        check("tx_valid_full", 32'(uart_tx_valid), 32'h1);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tx_drain%0d_valid", i), 32'(uart_tx_valid), 32'h1);
            check($sformatf("tx_drain%0d_data", i), 32'(uart_tx_data), 32'(8'h11 + i));
            @(negedge clk);
        end
        check("tx_byte5_absent", 32'(uart_tx_valid), 32'h0);
        uart_tx_ready = 1'b0;

        // Write to a full FIFO during a pop is accepted
        acc(3'd0, 4'b0001, 32'h2);
        for (int i = 0; i < 4; i++) acc(3'd2, 4'b0001, 32'(8'h21 + i));
        uart_tx_ready = 1'b1;
        acc(3'd2, 4'b0001, 32'h25);
        uart_tx_ready = 1'b0;
        acc(3'd1, 4'h0, 32'h0);
        check("status_full_pop", mmio_rdata, 32'h0004_0002);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tx_fp%0d_data", i), 32'(uart_tx_data), 32'(8'h22 + i));
            @(negedge clk);
        end
        uart_tx_ready = 1'b0;
        acc(3'd1, 4'h0, 32'h0);
        check("status_tx_empty", mmio_rdata, 32'h0);

        // RX fill, backpressure and pops
        for (int i = 0; i < 4; i++) begin
            uart_rx_data  = 8'(8'hA1 + i);
            uart_rx_valid = 1'b1;
            @(negedge clk);
        end
        uart_rx_valid = 1'b0;
        check("rx_ready_full", 32'(uart_rx_ready), 32'h0);
        acc(3'd1, 4'h0, 32'h0);
        check("status_rx_full", mmio_rdata, 32'h0000_0401);
        for (int i = 0; i < 5; i++) begin
            acc(3'd3, 4'h0, 32'h0);
            check($sformatf("rx_pop%0d", i), mmio_rdata, (i < 4) ? 32'(8'hA1 + i) : 32'h0);
            if (i == 0) check("rx_ready_after_pop", 32'(uart_rx_ready), 32'h1);
        end

        // Asynchronous reset with TX data pending
        acc(3'd2, 4'b0001, 32'h31);
        acc(3'd2, 4'b0001, 32'h32);
        acc(3'd4, 4'h0, 32'h0);
        check("tx_valid_pre_rst", 32'(uart_tx_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async_tx_valid", 32'(uart_tx_valid), 32'h0);
        check("async_tx_data",  32'(uart_tx_data), 32'h0);
        check("async_rdata",    mmio_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        acc(3'd1, 4'h0, 32'h0);
        check("status_after_rst", mmio_rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
